// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared address map, region and FSM state types for the MEM-stage bus controller
package mem_bus_ctrl_pkg;
  localparam logic [31:0] StartAddrDM    = 32'h0000_0000;
  localparam logic [31:0] EndAddrDM      = 32'h0000_2fff;
  localparam logic [31:0] StartAddrTC0   = 32'h0000_7f00;
  localparam logic [31:0] EndAddrTC0     = 32'h0000_7f0b;
  localparam logic [31:0] StartAddrTC1   = 32'h0000_7f10;
  localparam logic [31:0] EndAddrTC1     = 32'h0000_7f1b;
  localparam logic [31:0] StartAddrStall = 32'h0000_7f20;
  localparam logic [31:0] EndAddrStall   = 32'h0000_7f23;
  typedef enum logic [2:0] {REG_DM, REG_TC0, REG_TC1, REG_STALL, REG_UNMAPPED} region_e;
  typedef enum logic [1:0] {S_IDLE, S_DM_WAIT, S_DELAY} state_e;
  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo, input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction
endpackage

// File: rtl/mem_bus_ctrl_addr_region_dec.sv
// addr_region_dec: maps a byte address onto DM, TC0, TC1, STALL or UNMAPPED (addr in, region out)
module addr_region_dec
  import mem_bus_ctrl_pkg::*;
(
  input  logic [31:0] addr,
  output region_e     region
);
  always_comb
    region = in_range(addr, StartAddrDM, EndAddrDM)       ? REG_DM    :
             in_range(addr, StartAddrTC0, EndAddrTC0)     ? REG_TC0   :
             in_range(addr, StartAddrTC1, EndAddrTC1)     ? REG_TC1   :
             in_range(addr, StartAddrStall, EndAddrStall) ? REG_STALL : REG_UNMAPPED;
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences MEM-stage accesses onto DM, TC0/TC1 and the stall device; cpu_* side in, dm_*/tc* side out, cpu_stall holds the pipeline
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int DM_WAIT = 2,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_exc,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_byteen,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        dm_en,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic [29:0] tc_addr,
  output logic [31:0] tc_wdata,
  output logic        tc0_we,
  output logic        tc1_we,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata
);
  localparam int CW = CNT_W > $clog2(DM_WAIT + 2) ? CNT_W : $clog2(DM_WAIT + 2);
  state_e            state;
  region_e           region;
  logic [CW-1:0]     cnt;
  logic [CNT_W-1:0]  stall_reg;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_byteen;
  logic              lat_we;
  logic              valid;
  logic              full;
  logic [CNT_W-1:0]  n;
  addr_region_dec u_dec (.addr(cpu_addr), .region(region));
  assign valid    = cpu_req && !cpu_exc;
  assign full     = cpu_byteen == 4'hf;
  assign n        = cpu_wdata[CNT_W-1:0];
  assign tc_addr  = cpu_addr[31:2];
  assign tc_wdata = cpu_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      stall_reg  <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_byteen <= '0;
      lat_we     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid && region == REG_DM && DM_WAIT != 0) begin
            lat_addr   <= cpu_addr;
            lat_wdata  <= cpu_wdata;
            lat_byteen <= cpu_byteen;
            lat_we     <= cpu_we;
            cnt        <= CW'(DM_WAIT);
            state      <= S_DM_WAIT;
          end
          if (valid && region == REG_STALL && cpu_we && full) begin
            stall_reg <= n;
            if (n != '0) begin
              cnt   <= CW'(n) - CW'(1);
              state <= S_DELAY;
            end
          end
        end
        S_DM_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_IDLE;
        end
        S_DELAY: begin
          cnt <= cnt == '0 ? '0 : cnt - CW'(1);
          if (cnt == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // Strobes are gated by reset so an access cut short by reset never commits.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    dm_en     = 1'b0;
    dm_we     = '0;
    dm_addr   = cpu_addr;
    dm_wdata  = cpu_wdata;
    tc0_we    = 1'b0;
    tc1_we    = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            case (region)
              REG_DM: begin
                dm_en     = 1'b1;
                cpu_stall = DM_WAIT != 0;
                if (DM_WAIT == 0) begin
                  dm_we     = cpu_we ? cpu_byteen : 4'h0;
                  cpu_rdata = dm_rdata;
                end
              end
              REG_TC0: begin
                tc0_we    = cpu_we && full;
                cpu_rdata = cpu_we ? '0 : tc0_rdata;
              end
              REG_TC1: begin
                tc1_we    = cpu_we && full;
                cpu_rdata = cpu_we ? '0 : tc1_rdata;
              end
              REG_STALL: begin
                cpu_stall = cpu_we && full && n != '0;
                cpu_rdata = cpu_we ? '0 : 32'(stall_reg);
              end
              default: ;
            endcase
          end
        end
        S_DM_WAIT: begin
          dm_en     = 1'b1;
          dm_addr   = lat_addr;
          dm_wdata  = lat_wdata;
          cpu_stall = cnt != CW'(1);
          if (cnt == CW'(1)) begin
            dm_we     = lat_we ? lat_byteen : 4'h0;
            cpu_rdata = dm_rdata;
          end
        end
        S_DELAY: cpu_stall = cnt != '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: scoreboard bench; stimulus queues per-cycle expectations, a negedge monitor pops and compares
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_exc = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_byteen = '0;
  logic [31:0] cpu_rdata, dm_addr, dm_wdata, tc_wdata;
  logic        cpu_stall, dm_en, tc0_we, tc1_we;
  logic [3:0]  dm_we;
  logic [29:0] tc_addr;
  logic [31:0] dm_rdata = 32'hdeadbeef, tc0_rdata = 32'ha5a50000, tc1_rdata = 32'h5a5a1111;
  typedef struct {
    string       nm;
    logic        st;
    logic [31:0] rd;
    logic        en;
    logic [3:0]  dwe;
    logic        w0;
    logic        w1;
    logic [31:0] da;
    logic        ca;
    logic [29:0] ta;
    logic        ct;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  mem_bus_ctrl #(.DM_WAIT(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_exc(cpu_exc), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .dm_en(dm_en), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .tc_addr(tc_addr), .tc_wdata(tc_wdata), .tc0_we(tc0_we), .tc1_we(tc1_we),
    .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input string f, input logic [31:0] a, input logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", nm, f, a, x);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "cpu_stall", 32'(cpu_stall), 32'(e.st));
      chk(e.nm, "cpu_rdata", cpu_rdata, e.rd);
      chk(e.nm, "dm_en", 32'(dm_en), 32'(e.en));
      chk(e.nm, "dm_we", 32'(dm_we), 32'(e.dwe));
      chk(e.nm, "tc0_we", 32'(tc0_we), 32'(e.w0));
      chk(e.nm, "tc1_we", 32'(tc1_we), 32'(e.w1));
      if (e.ca) chk(e.nm, "dm_addr", dm_addr, e.da);
      if (e.ct) chk(e.nm, "tc_addr", 32'(tc_addr), 32'(e.ta));
    end
  end
  task automatic drv(input logic req, input logic exc, input logic we, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    cpu_req = req; cpu_exc = exc; cpu_we = we; cpu_addr = a; cpu_byteen = be; cpu_wdata = wd;
  endtask
  task automatic step(input string nm, input logic st, input logic [31:0] rd, input logic en,
                      input logic [3:0] dwe, input logic w0, input logic w1, input logic [31:0] da,
                      input logic ca, input logic [29:0] ta, input logic ct);
    exp_t e;
    e.nm = nm; e.st = st; e.rd = rd; e.en = en; e.dwe = dwe; e.w0 = w0; e.w1 = w1;
    e.da = da; e.ca = ca; e.ta = ta; e.ct = ct;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic dmx(input string nm, input logic st, input logic [31:0] rd, input logic [3:0] dwe, input logic [31:0] da);
    step(nm, st, rd, 1'b1, dwe, 1'b0, 1'b0, da, 1'b1, '0, 1'b0);
  endtask
  task automatic nil(input string nm, input logic st, input logic [31:0] rd);
    step(nm, st, rd, 1'b0, 4'h0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask
  task automatic tcx(input string nm, input logic [31:0] rd, input logic w0, input logic w1, input logic [29:0] ta);
    step(nm, 1'b0, rd, 1'b0, 4'h0, w0, w1, '0, 1'b0, ta, 1'b1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    drv(1, 0, 1, 32'h10, 4'hf, 32'h1);
    nil("rst", 0, 0);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    nil("idle", 0, 0);
    drv(1, 0, 0, 32'h10, 4'hf, 0);
    dmx("ld0", 1, 0, 0, 32'h10);
    dmx("ld1", 1, 0, 0, 32'h10);
    dmx("ld2", 0, 32'hdeadbeef, 0, 32'h10);
    drv(1, 0, 1, 32'h2ffc, 4'h3, 32'h1234abcd);
    dmx("st0", 1, 0, 0, 32'h2ffc);
    cpu_addr = 32'h0bad_0000;
    dmx("st1", 1, 0, 0, 32'h2ffc);
    dmx("st2", 0, 32'hdeadbeef, 4'h3, 32'h2ffc);
    drv(1, 0, 1, 32'h7f20, 4'hf, 32'h5);
    for (int i = 0; i < 5; i++) nil($sformatf("dly%0d", i), 1, 0);
    nil("dly5", 0, 0);
    drv(1, 0, 0, 32'h7f20, 4'hf, 0);
    nil("ldstl", 0, 32'h5);
    drv(1, 0, 1, 32'h7f20, 4'h3, 32'h9);
    nil("shstl", 0, 0);
    drv(1, 0, 0, 32'h7f23, 4'hf, 0);
    nil("ldstl_hi", 0, 32'h5);
    drv(1, 0, 1, 32'h7f20, 4'hf, 32'hffff_0000);
    nil("st0stl", 0, 0);
    drv(1, 0, 0, 32'h7f20, 4'hf, 0);
    nil("ldstl0", 0, 32'h0);
    drv(1, 0, 1, 32'h7f14, 4'hf, 32'h77);
    tcx("swtc1", 0, 0, 1, 30'h1fc5);
    drv(1, 0, 1, 32'h7f04, 4'h3, 32'h77);
    tcx("shtc0", 0, 0, 0, 30'h1fc1);
    drv(1, 0, 1, 32'h7f00, 4'hf, 32'h1);
    tcx("swtc0", 0, 1, 0, 30'h1fc0);
    drv(1, 0, 0, 32'h7f0b, 4'hf, 0);
    tcx("ldtc0", 32'ha5a50000, 0, 0, 30'h1fc2);
    drv(1, 0, 0, 32'h7f18, 4'hf, 0);
    tcx("ldtc1", 32'h5a5a1111, 0, 0, 30'h1fc6);
    drv(1, 0, 0, 32'h7f0c, 4'hf, 0);
    nil("ld7f0c", 0, 0);
    drv(1, 0, 1, 32'h7f24, 4'hf, 32'h3);
    nil("st7f24", 0, 0);
    drv(1, 0, 0, 32'h3000, 4'hf, 0);
    nil("ld3000", 0, 0);
    drv(1, 1, 1, 32'h10, 4'hf, 32'h1);
    nil("exc", 0, 0);
    drv(0, 0, 1, 32'h10, 4'hf, 32'h1);
    nil("noreq", 0, 0);
    drv(1, 0, 1, 32'h100, 4'hf, 32'hcafef00d);
    dmx("rs0", 1, 0, 0, 32'h100);
    dmx("rs1", 1, 0, 0, 32'h100);
    reset = 1'b1;
    nil("rs2", 0, 0);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    nil("rs3", 0, 0);
    drv(1, 0, 0, 32'h2fff, 4'hf, 0);
    dmx("post0", 1, 0, 0, 32'h2fff);
    dmx("post1", 1, 0, 0, 32'h2fff);
    dmx("post2", 0, 32'hdeadbeef, 0, 32'h2fff);
    drv(0, 0, 0, 0, 0, 0);
    nil("end", 0, 0);
    @(posedge clk);
    #1;
    chk("drain", "pending", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
